// File: rtl/frame_stream_gen.sv
// frame_stream_gen - AXI4-Stream frame source.
//
// On an accepted start, emits one frame of y_size rows. Each row holds x_size
// pixels of pixel_width bytes, packed little-endian into 64-bit beats. Every
// component byte of pixel p carries p mod 256. The tuser sync bits mark the
// first and last beats of each row (SOF/EOF/SOL/EOL).
//
// Optional build macro: FRAME_GEN_ROW_SEED_EN
//   When defined, each pixel byte becomes (p + row_index) mod 256, so row
//   order is visible in the data. Sync, sizing and timing do not change.
//
// Ports:
//   aclk              clock
//   aclk_reset        synchronous active-high reset (clears all outputs)
//   aclk_start        one-cycle frame start request
//   aclk_pixel_width  bytes per pixel (1..4)
//   aclk_x_size       pixels per row (1..8191)
//   aclk_y_size       rows per frame (1..8191)
//   aclk_line_gap     idle cycles between rows
//   aclk_busy         frame in progress
//   aclk_frame_done   one-cycle pulse after the EOF beat is accepted
//   aclk_cfg_error    one-cycle pulse when a start is rejected
//   aclk_tvalid/tready/tdata/tuser/tlast  AXI4-Stream master
//                     tuser: [0]=SOF [1]=EOF [2]=SOL [3]=EOL
module frame_stream_gen #(
  parameter int LINE_GAP_W = 16
) (
  input  logic                  aclk,
  input  logic                  aclk_reset,
  input  logic                  aclk_start,
  input  logic [2:0]            aclk_pixel_width,
  input  logic [12:0]           aclk_x_size,
  input  logic [12:0]           aclk_y_size,
  input  logic [LINE_GAP_W-1:0] aclk_line_gap,
  output logic                  aclk_busy,
  output logic                  aclk_frame_done,
  output logic                  aclk_cfg_error,
  output logic                  aclk_tvalid,
  input  logic                  aclk_tready,
  output logic [63:0]           aclk_tdata,
  output logic [3:0]            aclk_tuser,
  output logic                  aclk_tlast
);

  typedef enum logic [1:0] {ST_IDLE, ST_ROW, ST_GAP} state_t;

  function automatic logic [7:0] pix_byte(input logic [7:0] p, input logic [7:0] seed);
    return p + seed;
  endfunction

  // Control / counter stage (p0)
  state_t                state_p0, nxt_state;
  logic [1:0]            pw_m1_p0;
  logic [12:0]           y_last_p0;
  logic [LINE_GAP_W-1:0] gap_p0;
  logic [LINE_GAP_W-1:0] gcnt_p0;
  logic [15:0]           row_bytes_p0;
  logic [12:0]           pix_p0;
  logic [1:0]            comp_p0;
  logic [15:0]           left_p0;
  logic [12:0]           row_p0;
  logic                  row_loaded_p0;
  logic                  err_p0;
  logic                  done_p0;

  // Output register stage (p1)
  logic                  vld_p1;
  logic [63:0]           data_p1;
  logic [3:0]            user_p1;
  logic                  last_p1;
  logic                  busy_p1;
  logic                  done_p1;
  logic                  err_p1;

  logic        acc, last_acc, final_row, can_load, legal;
  logic        accept, reject, load, restart, enter_gap, eof;
  logic [15:0] rb_in;

  logic [12:0] v_pix, n_pix, v_row;
  logic [1:0]  v_comp, n_comp;
  logic [15:0] v_left, n_left;
  logic [63:0] beat;
  logic        b_first, b_last;
  logic [3:0]  b_user;
  logic [7:0]  seed;

  assign rb_in     = 16'(aclk_x_size) * 16'(aclk_pixel_width);
  assign legal     = (aclk_pixel_width != 3'd0) && (aclk_pixel_width <= 3'd4) &&
                     (aclk_x_size != 13'd0) && (aclk_y_size != 13'd0);
  assign acc       = vld_p1 & aclk_tready;
  assign last_acc  = acc & last_p1;
  assign final_row = (row_p0 == y_last_p0);
  assign can_load  = !vld_p1 || aclk_tready;

  // Next-state and load control
  always_comb begin
    nxt_state = state_p0;
    accept    = 1'b0;
    reject    = 1'b0;
    load      = 1'b0;
    restart   = 1'b0;
    enter_gap = 1'b0;
    eof       = 1'b0;
    case (state_p0)
      ST_IDLE: begin
        if (aclk_start) begin
          if (legal) begin
            accept    = 1'b1;
            nxt_state = ST_ROW;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_ROW: begin
        if (last_acc) begin
          if (final_row) begin
            eof       = 1'b1;
            nxt_state = ST_IDLE;
          end else if (gap_p0 != '0) begin
            enter_gap = 1'b1;
            nxt_state = ST_GAP;
          end else begin
            // Zero gap: the next row's first beat replaces the accepted
            // last beat on the same edge, keeping rows back-to-back.
            restart = 1'b1;
            load    = 1'b1;
          end
        end else if (!row_loaded_p0 && can_load) begin
          load = 1'b1;
        end
      end
      ST_GAP: begin
        if (gcnt_p0 == LINE_GAP_W'(1)) begin
          load      = 1'b1;
          nxt_state = ST_ROW;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  // Beat assembly: walks the pixel/component counters byte by byte so no
  // divider is needed. restart presents a fresh-row view of the counters.
  always_comb begin
    v_pix  = pix_p0;
    v_comp = comp_p0;
    v_left = left_p0;
    v_row  = row_p0;
    if (restart) begin
      v_pix  = '0;
      v_comp = '0;
      v_left = row_bytes_p0;
      v_row  = row_p0 + 13'd1;
    end
`ifdef FRAME_GEN_ROW_SEED_EN
    seed = v_row[7:0];
`else
    seed = 8'd0;
`endif
    n_pix  = v_pix;
    n_comp = v_comp;
    beat   = '0;
    for (int i = 0; i < 8; i++) begin
      if (16'(i) < v_left) begin
        beat[8*i +: 8] = pix_byte(n_pix[7:0], seed);
        if (n_comp == pw_m1_p0) begin
          n_comp = '0;
          n_pix  = n_pix + 13'd1;
        end else begin
          n_comp = n_comp + 2'd1;
        end
      end
    end
    n_left  = (v_left > 16'd8) ? (v_left - 16'd8) : 16'd0;
    b_first = (v_left == row_bytes_p0);
    b_last  = (v_left <= 16'd8);
    b_user  = 4'b0000;
    if (b_first) b_user = b_user | ((v_row == 13'd0) ? 4'b0001 : 4'b0100);
    if (b_last)  b_user = b_user | ((v_row == y_last_p0) ? 4'b0010 : 4'b1000);
  end

  // Control registers and output stage
  always_ff @(posedge aclk) begin
    if (aclk_reset) begin
      state_p0      <= ST_IDLE;
      row_loaded_p0 <= 1'b0;
      err_p0        <= 1'b0;
      done_p0       <= 1'b0;
      vld_p1        <= 1'b0;
      data_p1       <= '0;
      user_p1       <= '0;
      last_p1       <= 1'b0;
      busy_p1       <= 1'b0;
      done_p1       <= 1'b0;
      err_p1        <= 1'b0;
    end else begin
      state_p0 <= nxt_state;
      err_p0   <= reject;
      done_p0  <= eof;
      err_p1   <= err_p0;
      done_p1  <= done_p0;
      busy_p1  <= (state_p0 != ST_IDLE);
      if (load) begin
        vld_p1        <= 1'b1;
        data_p1       <= beat;
        user_p1       <= b_user;
        last_p1       <= b_last;
        row_loaded_p0 <= b_last;
      end else if (acc) begin
        vld_p1 <= 1'b0;
      end
      if (accept || enter_gap) row_loaded_p0 <= 1'b0;
    end
  end

  // Config latch and row counters
  always_ff @(posedge aclk) begin
    if (accept) begin
      pw_m1_p0     <= 2'(aclk_pixel_width - 3'd1);
      y_last_p0    <= aclk_y_size - 13'd1;
      gap_p0       <= aclk_line_gap;
      row_bytes_p0 <= rb_in;
      pix_p0       <= '0;
      comp_p0      <= '0;
      left_p0      <= rb_in;
      row_p0       <= '0;
    end else if (load) begin
      pix_p0  <= n_pix;
      comp_p0 <= n_comp;
      left_p0 <= n_left;
      row_p0  <= v_row;
    end else if (enter_gap) begin
      pix_p0  <= '0;
      comp_p0 <= '0;
      left_p0 <= row_bytes_p0;
      row_p0  <= row_p0 + 13'd1;
    end
    if (enter_gap) begin
      gcnt_p0 <= gap_p0;
    end else if (state_p0 == ST_GAP) begin
      gcnt_p0 <= gcnt_p0 - LINE_GAP_W'(1);
    end
  end

  assign aclk_tvalid     = vld_p1;
  assign aclk_tdata      = data_p1;
  assign aclk_tuser      = user_p1;
  assign aclk_tlast      = last_p1;
  assign aclk_busy       = busy_p1;
  assign aclk_frame_done = done_p1;
  assign aclk_cfg_error  = err_p1;

endmodule

// File: tb/tb_frame_stream_gen.sv
// Directed testbench for frame_stream_gen.
module tb_frame_stream_gen;

  logic        aclk = 1'b0;
  logic        aclk_reset;
  logic        aclk_start;
  logic [2:0]  aclk_pixel_width;
  logic [12:0] aclk_x_size;
  logic [12:0] aclk_y_size;
  logic [15:0] aclk_line_gap;
  logic        aclk_busy;
  logic        aclk_frame_done;
  logic        aclk_cfg_error;
  logic        aclk_tvalid;
  logic        aclk_tready;
  logic [63:0] aclk_tdata;
  logic [3:0]  aclk_tuser;
  logic        aclk_tlast;

  always #5 aclk = ~aclk;

  frame_stream_gen #(.LINE_GAP_W(16)) dut (
    .aclk             (aclk),
    .aclk_reset       (aclk_reset),
    .aclk_start       (aclk_start),
    .aclk_pixel_width (aclk_pixel_width),
    .aclk_x_size      (aclk_x_size),
    .aclk_y_size      (aclk_y_size),
    .aclk_line_gap    (aclk_line_gap),
    .aclk_busy        (aclk_busy),
    .aclk_frame_done  (aclk_frame_done),
    .aclk_cfg_error   (aclk_cfg_error),
    .aclk_tvalid      (aclk_tvalid),
    .aclk_tready      (aclk_tready),
    .aclk_tdata       (aclk_tdata),
    .aclk_tuser       (aclk_tuser),
    .aclk_tlast       (aclk_tlast)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] qd[$];
  logic [3:0]  qu[$];
  logic        ql[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  function automatic int row_seed(int r);
`ifdef FRAME_GEN_ROW_SEED_EN
    return r;
`else
    return 0;
`endif
  endfunction

  function automatic logic [63:0] exp_beat(int pw, int x, int r, int b);
    logic [63:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      int k;
      k = b * 8 + i;
      if (k < x * pw) d[8*i +: 8] = 8'(((k / pw) + row_seed(r)) % 256);
    end
    return d;
  endfunction

  function automatic logic [3:0] exp_user(int r, int b, int nb, int y);
    logic [3:0] u;
    u = 4'b0000;
    if (b == 0)      u = u | ((r == 0) ? 4'b0001 : 4'b0100);
    if (b == nb - 1) u = u | ((r == y - 1) ? 4'b0010 : 4'b1000);
    return u;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_tvalid"}, aclk_tvalid, 0);
    chk({tag, "_tdata"}, aclk_tdata, 0);
    chk({tag, "_tuser"}, aclk_tuser, 0);
    chk({tag, "_tlast"}, aclk_tlast, 0);
    chk({tag, "_busy"}, aclk_busy, 0);
    chk({tag, "_done"}, aclk_frame_done, 0);
    chk({tag, "_cfgerr"}, aclk_cfg_error, 0);
  endtask

  // Starts a frame and consumes it, checking every beat against the model,
  // stall stability, row gaps, start latency and frame-end timing.
  // poke >= 0 pulses a second start with a different config at that cycle.
  task automatic run_frame(input int pw, input int x, input int y, input int gap,
                           input bit rnd, input int poke);
    int nb, r, b, cyc, gapc, eof_cyc, errs;
    bit in_gap, stall, fin;
    logic [63:0] pd;
    logic [3:0]  pu;
    logic        pl;
    nb = (x * pw + 7) / 8;
    r = 0; b = 0; cyc = 0; gapc = 0; eof_cyc = -100; errs = 0;
    in_gap = 0; stall = 0; fin = 0;
    pd = '0; pu = '0; pl = 1'b0;
    qd.delete(); qu.delete(); ql.delete();
    aclk_pixel_width = 3'(pw);
    aclk_x_size      = 13'(x);
    aclk_y_size      = 13'(y);
    aclk_line_gap    = 16'(gap);
    aclk_start       = 1'b1;
    tick;
    aclk_start = 1'b0;
    while (!fin && cyc < 20000) begin
      if (cyc == 0) begin
        chk("lat0_tvalid", aclk_tvalid, 0);
        chk("lat0_busy", aclk_busy, 0);
      end
      if (cyc == 1) begin
        chk("lat1_tvalid", aclk_tvalid, 1);
        chk("lat1_busy", aclk_busy, 1);
      end
      if (poke >= 0 && cyc == poke) begin
        aclk_pixel_width = 3'd3;
        aclk_x_size      = 13'd5;
        aclk_y_size      = 13'd1;
        aclk_line_gap    = 16'd7;
        aclk_start       = 1'b1;
      end else begin
        aclk_start = 1'b0;
      end
      if (aclk_cfg_error) errs++;
      if (stall) begin
        chk("stall_tvalid", aclk_tvalid, 1);
        chk("stall_tdata", aclk_tdata, pd);
        chk("stall_tuser", aclk_tuser, pu);
        chk("stall_tlast", aclk_tlast, pl);
      end
      aclk_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (aclk_tvalid) begin
        if (in_gap) begin
          chk("gap_len", gapc, gap);
          in_gap = 0;
        end
      end else if (in_gap) begin
        gapc++;
      end
      if (aclk_tvalid && aclk_tready) begin
        qd.push_back(aclk_tdata);
        qu.push_back(aclk_tuser);
        ql.push_back(aclk_tlast);
        chk("beat_tdata", aclk_tdata, exp_beat(pw, x, r, b));
        chk("beat_tuser", aclk_tuser, exp_user(r, b, nb, y));
        chk("beat_tlast", aclk_tlast, (b == nb - 1) ? 1 : 0);
        b++;
        if (b == nb) begin
          b = 0;
          r++;
          if (r == y) eof_cyc = cyc;
          else begin
            in_gap = 1;
            gapc   = 0;
          end
        end
      end
      stall = aclk_tvalid && !aclk_tready;
      pd = aclk_tdata;
      pu = aclk_tuser;
      pl = aclk_tlast;
      if (aclk_frame_done) begin
        chk("done_latency", cyc - eof_cyc, 2);
        chk("busy_at_done", aclk_busy, 0);
        fin = 1;
      end
      tick;
      cyc++;
    end
    aclk_start  = 1'b0;
    aclk_tready = 1'b1;
    chk("frame_finished", fin, 1);
    chk("rows_seen", r, y);
    chk("beats_seen", qd.size(), nb * y);
    chk("no_cfg_error", errs, 0);
    chk("done_single_pulse", aclk_frame_done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected frame completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  bad_pw[4];
    logic [12:0] bad_x[4];
    logic [12:0] bad_y[4];
    bit          found;
    int          n;
    bad_pw = '{3'd0, 3'd5, 3'd1, 3'd2};
    bad_x  = '{13'd4, 13'd4, 13'd0, 13'd9};
    bad_y  = '{13'd1, 13'd2, 13'd3, 13'd0};

    aclk_reset       = 1'b1;
    aclk_start       = 1'b0;
    aclk_pixel_width = 3'd1;
    aclk_x_size      = 13'd1;
    aclk_y_size      = 13'd1;
    aclk_line_gap    = 16'd0;
    aclk_tready      = 1'b1;
    tick;
    tick;
    check_all_zero("reset");
    aclk_reset = 1'b0;
    tick;

    // pw=1, x=256, y=5, gap=0
    run_frame(1, 256, 5, 0, 0, -1);
    chk("a_beat0_data", qd[0], 64'h0706050403020100);
    chk("a_beat0_user", qu[0], 4'b0001);
    chk("a_row0_last_user", qu[31], 4'b1000);
    chk("a_row0_last_tlast", ql[31], 1);
    chk("a_row3_last_user", qu[127], 4'b1000);
    chk("a_row4_last_user", qu[159], 4'b0010);
    chk("a_row4_last_tlast", ql[159], 1);
    chk("a_row1_first_user", qu[32], 4'b0100);
    tick;

    // pw=2, x=13, y=2, gap=3
    run_frame(2, 13, 2, 3, 0, -1);
    chk("b_row0_last_data", qd[3], 64'h0000000000000C0C);
    chk("b_row1_first_user", qu[4], 4'b0100);
    chk("b_row1_last_user", qu[7], 4'b0010);
    tick;

    // pw=1, x=4, y=1: single beat, single row
    run_frame(1, 4, 1, 0, 0, -1);
    chk("c_data", qd[0], 64'h0000000003020100);
    chk("c_user", qu[0], 4'b0011);
    chk("c_tlast", ql[0], 1);
    tick;

    // Random backpressure, pw=4, x=100, y=3
    run_frame(4, 100, 3, 2, 1, -1);
    chk("d_beats", qd.size(), 150);
    chk("d_row0_beat0", qd[0], 64'h0101010100000000);
    tick;

    // Illegal configs
    for (int i = 0; i < 4; i++) begin
      aclk_pixel_width = bad_pw[i];
      aclk_x_size      = bad_x[i];
      aclk_y_size      = bad_y[i];
      aclk_start       = 1'b1;
      tick;
      aclk_start = 1'b0;
      chk("bad_cfgerr_early", aclk_cfg_error, 0);
      tick;
      chk("bad_cfgerr_pulse", aclk_cfg_error, 1);
      chk("bad_tvalid", aclk_tvalid, 0);
      chk("bad_busy", aclk_busy, 0);
      tick;
      chk("bad_cfgerr_end", aclk_cfg_error, 0);
      chk("bad_tvalid_end", aclk_tvalid, 0);
    end

    // Start while busy with a different config is ignored
    run_frame(1, 64, 2, 2, 0, 5);
    tick;

    // Reset mid-frame at row 1 beat 5 (pw=1, x=64: 8 beats per row)
    aclk_pixel_width = 3'd1;
    aclk_x_size      = 13'd64;
    aclk_y_size      = 13'd3;
    aclk_line_gap    = 16'd0;
    aclk_tready      = 1'b1;
    aclk_start       = 1'b1;
    tick;
    aclk_start = 1'b0;
    found = 0;
    n = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (aclk_tvalid) begin
        if (n == 13) found = 1;
        else n++;
      end
      if (!found) tick;
    end
    chk("rst_point_found", found, 1);
    chk("rst_point_user", aclk_tuser, 4'b0000);
    aclk_reset = 1'b1;
    tick;
    check_all_zero("midrst");
    aclk_reset = 1'b0;
    tick;
    check_all_zero("midrst_after");
    run_frame(1, 64, 3, 0, 0, -1);
    tick;

    // Row seed visibility
    run_frame(1, 8, 3, 0, 0, -1);
`ifdef FRAME_GEN_ROW_SEED_EN
    chk("seed_row2_beat0", qd[2], 64'h0908070605040302);
`else
    chk("seed_row2_beat0", qd[2], 64'h0706050403020100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
